wm_phase_executor: RTL and testbench

- Appliance-side executor for the washing-machine controller's operation commands (soak/wash/rinse/spin plus water intake).
- Times each phase and drives the valve, motor and drain actuators.
- Returns a one-cycle phase_done pulse so the controller can advance its state machine.
- Sits between the controller outputs and the actuator pins.

---
 rtl/wm_phase_executor.sv | 201 ++++++++++++++++++++
 tb/tb_wm_phase_executor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_phase_executor.sv
// Phase executor for the washing-machine controller: times fill/run/drain and drives the actuators.
// Optional WM_LID_PAUSE_EN: lid open pauses an active phase instead of faulting.
module wm_phase_executor #(
   parameter int FILL_CYCLES  = 8,
   parameter int SOAK_CYCLES  = 16,
   parameter int WASH_CYCLES  = 32,
   parameter int RINSE_CYCLES = 16,
   parameter int SPIN_CYCLES  = 24,
   parameter int DRAIN_CYCLES = 8,
   parameter int CNT_W        = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       soak_Operation,
   input  logic       wash_Operation,
   input  logic       rinse_Operation,
   input  logic       spin_Operation,
   input  logic       water_Intake,
   input  logic       lid,
   input  logic       cancel,
   output logic       valve_open,
   output logic       motor_on,
   output logic       motor_fast,
   output logic       drain_open,
   output logic       lid_lock,
   output logic       busy,
   output logic       phase_done,
   output logic [2:0] phase_code,
   output logic       fault,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYCLES - 1);
   localparam logic [CNT_W-1:0] SOAK_LD  = CNT_W'(SOAK_CYCLES - 1);
   localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_CYCLES - 1);
   localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 1);

   // Op vector bit order: {spin, rinse, wash, soak}; latched copy is one-hot.
   function automatic logic [CNT_W-1:0] run_ld(input logic [3:0] op);
      logic [CNT_W-1:0] v;
      v = SPIN_LD;
      if (op[0])      v = SOAK_LD;
      else if (op[1]) v = WASH_LD;
      else if (op[2]) v = RINSE_LD;
      return v;
   endfunction

   function automatic logic [2:0] code_of(input logic [3:0] op);
      logic [2:0] c;
      c = 3'd4;
      if (op[0])      c = 3'd1;
      else if (op[1]) c = 3'd2;
      else if (op[2]) c = 3'd3;
      return c;
   endfunction

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [3:0]       op_q, op_n;
   logic             abort_q, abort_n;
   logic [3:0]       op_vec;
   logic             op_held, stop, active, active_n, pause, lid_trip, hush;

   assign op_vec   = {spin_Operation, rinse_Operation, wash_Operation, soak_Operation};
   assign op_held  = |(op_q & op_vec);
   assign stop     = cancel || !op_held;
   assign active   = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign active_n = (state_n == S_FILL) || (state_n == S_RUN) || (state_n == S_DRAIN);
   assign dbg_state = state_q;

`ifdef WM_LID_PAUSE_EN
   assign pause    = lid && active;
   assign lid_trip = 1'b0;
   assign hush     = lid && active_n;
`else
   assign pause    = 1'b0;
   assign lid_trip = lid && lid_lock;
   assign hush     = 1'b0;
`endif

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      op_n    = op_q;
      abort_n = abort_q;
      case (state_q)
         S_IDLE: begin
            cnt_n   = '0;
            abort_n = 1'b0;
            if ((op_vec & (op_vec - 4'd1)) != 4'd0) begin
               state_n = S_FAULT;
            end else if (op_vec != 4'd0) begin
               op_n = op_vec;
               if (water_Intake && !op_vec[3]) begin
                  state_n = S_FILL;
                  cnt_n   = FILL_LD;
               end else begin
                  state_n = S_RUN;
                  cnt_n   = run_ld(op_vec);
               end
            end
         end
         S_FILL, S_RUN: begin
            if (lid_trip) begin
               state_n = S_FAULT;
               cnt_n   = '0;
            end else if (stop) begin
               state_n = S_DRAIN;
               cnt_n   = DRAIN_LD;
               abort_n = 1'b1;
            end else if (pause) begin
               cnt_n = cnt_q;
            end else if (cnt_q != '0) begin
               cnt_n = cnt_q - 1'b1;
            end else if (state_q == S_FILL) begin
               state_n = S_RUN;
               cnt_n   = run_ld(op_q);
            end else if (op_q[2] || op_q[3]) begin
               state_n = S_DRAIN;
               cnt_n   = DRAIN_LD;
            end else begin
               state_n = S_DONE;
            end
         end
         S_DRAIN: begin
            if (lid_trip) begin
               state_n = S_FAULT;
               cnt_n   = '0;
            end else if (pause) begin
               cnt_n = cnt_q;
            end else if (cnt_q != '0) begin
               cnt_n = cnt_q - 1'b1;
            end else if (abort_q) begin
               state_n = S_IDLE;
               op_n    = '0;
            end else begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            cnt_n = '0;
            // Four-phase handshake: wait for the controller to drop its command.
            if (!op_held) begin
               state_n = S_IDLE;
               op_n    = '0;
            end
         end
         S_FAULT: cnt_n = '0;
         default: begin
            state_n = S_FAULT;
            cnt_n   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so actuators switch with the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         abort_q    <= 1'b0;
         valve_open <= 1'b0;
         motor_on   <= 1'b0;
         motor_fast <= 1'b0;
         drain_open <= 1'b0;
         lid_lock   <= 1'b0;
         busy       <= 1'b0;
         phase_done <= 1'b0;
         phase_code <= 3'd0;
         fault      <= 1'b0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         op_q       <= op_n;
         abort_q    <= abort_n;
         valve_open <= (state_n == S_FILL) && !hush;
         motor_on   <= (state_n == S_RUN) && !hush && (!op_n[0] || cnt_n[2]);
         motor_fast <= (state_n == S_RUN) && !hush && op_n[3];
         drain_open <= ((state_n == S_DRAIN) && !hush) || (state_n == S_FAULT);
         lid_lock   <= active_n;
         busy       <= (state_n != S_IDLE);
         phase_done <= (state_n == S_DONE) && (state_q != S_DONE);
         phase_code <= (state_n == S_IDLE)  ? 3'd0 :
                       (state_n == S_FAULT) ? 3'd7 : code_of(op_n);
         fault      <= (state_n == S_FAULT);
      end
   end

endmodule

// File: tb/tb_wm_phase_executor.sv
// Self-checking bench for wm_phase_executor: per-cycle output vectors against a phase-schedule model.
module tb_wm_phase_executor;

   localparam int FILL_C  = 8;
   localparam int DRAIN_C = 8;
   int run_len [4] = '{16, 32, 16, 24};

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] op_vec = 4'd0;
   logic       water_Intake = 1'b0;
   logic       lid = 1'b0;
   logic       cancel = 1'b0;
   logic       valve_open, motor_on, motor_fast, drain_open, lid_lock, busy, phase_done, fault;
   logic [2:0] phase_code, dbg_state;

   logic [10:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   wm_phase_executor dut (
      .clock(clock), .reset(reset),
      .soak_Operation(op_vec[0]), .wash_Operation(op_vec[1]),
      .rinse_Operation(op_vec[2]), .spin_Operation(op_vec[3]),
      .water_Intake(water_Intake), .lid(lid), .cancel(cancel),
      .valve_open(valve_open), .motor_on(motor_on), .motor_fast(motor_fast),
      .drain_open(drain_open), .lid_lock(lid_lock), .busy(busy),
      .phase_done(phase_done), .phase_code(phase_code), .fault(fault),
      .dbg_state(dbg_state)
   );

   wire [10:0] outs = {valve_open, motor_on, motor_fast, drain_open, lid_lock,
                       busy, phase_done, fault, phase_code};

   function automatic logic [10:0] ent(input bit valve, motor, fast, drain, lock, bsy, done, flt,
                                       input logic [2:0] code);
      return {valve, motor, fast, drain, lock, bsy, done, flt, code};
   endfunction

   // Schedule of one phase: fill cycles, run cycles (soak motor follows counter bit 2), then drain.
   task automatic model_phase(input int op, input bit water);
      int fill;
      logic [2:0] code;
      fill = (water && op != 3) ? FILL_C : 0;
      code = 3'(op + 1);
      for (int i = 0; i < fill; i++) exp_q.push_back(ent(1, 0, 0, 0, 1, 1, 0, 0, code));
      for (int j = 0; j < run_len[op]; j++) begin
         int left;
         bit m;
         left = run_len[op] - 1 - j;
         m = (op == 0) ? bit'((left >> 2) & 1) : 1'b1;
         exp_q.push_back(ent(0, m, op == 3, 0, 1, 1, 0, 0, code));
      end
      if (op >= 2)
         for (int k = 0; k < DRAIN_C; k++) exp_q.push_back(ent(0, 0, 0, 1, 1, 1, 0, 0, code));
   endtask

   task automatic model_done(input int op, input int hold);
      exp_q.push_back(ent(0, 0, 0, 0, 0, 1, 1, 0, 3'(op + 1)));
      repeat (hold) exp_q.push_back(ent(0, 0, 0, 0, 0, 1, 0, 0, 3'(op + 1)));
      exp_q.push_back(11'd0);
   endtask

   task automatic test_reset();
      logic [10:0] e;
      reset = 1'b1;
      op_vec = 4'(1 << $urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         if (i == 2) begin op_vec = 4'd0; reset = 1'b0; end
         e = 11'd0;
         n_cmp++;
         if (outs !== e) begin n_bad++; $display("FAIL reset[%0d]: got %b want %b", i, outs, e); end
      end
   endtask

   task automatic test_wash_fill();
      int n;
      logic [10:0] e;
      exp_q.delete();
      model_phase(1, 1'b1);
      model_done(1, 3);
      n = exp_q.size();
      water_Intake = 1'b1;
      op_vec = 4'b0010;
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin n_bad++; $display("FAIL wash_fill[%0d]: got %b want %b", i, outs, e); end
         if (i == n - 2) op_vec = 4'd0;
      end
      water_Intake = 1'b0;
   endtask

   task automatic test_random_ops();
      for (int t = 0; t < 6; t++) begin
         int op, hold, n;
         logic [10:0] e;
         op = (t == 0) ? 3 : $urandom_range(0, 3);
         hold = $urandom_range(0, 3);
         exp_q.delete();
         water_Intake = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         model_phase(op, water_Intake);
         model_done(op, hold);
         n = exp_q.size();
         op_vec = 4'(1 << op);
         for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (outs !== e) begin n_bad++; $display("FAIL random_op%0d[%0d]: got %b want %b", op, i, outs, e); end
            if (i == n - 2) op_vec = 4'd0;
         end
      end
      water_Intake = 1'b0;
   endtask

   task automatic test_cancel();
      for (int t = 0; t < 5; t++) begin
         int op, fill, c, n;
         bit by_drop;
         logic [10:0] e;
         op = (t == 0) ? 2 : $urandom_range(0, 3);
         water_Intake = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         fill = (water_Intake && op != 3) ? FILL_C : 0;
         c = (t == 0) ? fill + 5 : $urandom_range(1, fill + run_len[op]);
         by_drop = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         exp_q.delete();
         model_phase(op, water_Intake);
         while (exp_q.size() > c) void'(exp_q.pop_back());
         repeat (DRAIN_C) exp_q.push_back(ent(0, 0, 0, 1, 1, 1, 0, 0, 3'(op + 1)));
         exp_q.push_back(11'd0);
         n = exp_q.size();
         op_vec = 4'(1 << op);
         if (c == 0) op_vec = 4'd0;
         for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (outs !== e) begin n_bad++; $display("FAIL cancel_op%0d_at%0d[%0d]: got %b want %b", op, c, i, outs, e); end
            if (i == c - 1) begin
               if (by_drop) op_vec = 4'd0;
               else cancel = 1'b1;
            end
            if (i == c) begin cancel = 1'b0; op_vec = 4'd0; end
         end
      end
      water_Intake = 1'b0;
   endtask

   task automatic test_back_to_back();
      int a, b, ia, a_last, n;
      logic [10:0] e;
      a = $urandom_range(0, 3);
      b = (a + $urandom_range(1, 3)) % 4;
      water_Intake = 1'($urandom_range(0, 1));
      exp_q.delete();
      model_phase(a, water_Intake);
      ia = exp_q.size();
      model_done(a, 2);
      a_last = exp_q.size() - 2;
      model_phase(b, water_Intake);
      model_done(b, 1);
      n = exp_q.size();
      op_vec = 4'(1 << a);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin n_bad++; $display("FAIL back_to_back_%0d_%0d[%0d]: got %b want %b", a, b, i, outs, e); end
         if (i == ia) op_vec = op_vec | 4'(1 << b);
         if (i == a_last) op_vec = op_vec & ~4'(1 << a);
         if (i == n - 2) op_vec = 4'd0;
      end
      water_Intake = 1'b0;
   endtask

   task automatic test_multi_op_fault();
      int a, b;
      logic [10:0] e;
      a = $urandom_range(0, 3);
      b = (a + $urandom_range(1, 3)) % 4;
      exp_q.delete();
      repeat (4) exp_q.push_back(ent(0, 0, 0, 1, 0, 1, 0, 1, 3'd7));
      exp_q.push_back(11'd0);
      exp_q.push_back(11'd0);
      op_vec = 4'(1 << a) | 4'(1 << b);
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin n_bad++; $display("FAIL multi_op_fault[%0d]: got %b want %b", i, outs, e); end
         case (i)
            0: begin op_vec = 4'd0; cancel = 1'b1; end
            1: begin cancel = 1'b0; lid = 1'b1; end
            2: lid = 1'b0;
            3: reset = 1'b1;
            4: reset = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic test_lid();
      int c, n;
      logic [10:0] e;
      c = $urandom_range(3, 20);
      exp_q.delete();
      model_phase(1, 1'b0);
`ifdef WM_LID_PAUSE_EN
      model_done(1, 1);
      repeat (3) exp_q.insert(c, ent(0, 0, 0, 0, 1, 1, 0, 0, 3'd2));
`else
      while (exp_q.size() > c) void'(exp_q.pop_back());
      repeat (3) exp_q.push_back(ent(0, 0, 0, 1, 0, 1, 0, 1, 3'd7));
      exp_q.push_back(11'd0);
`endif
      n = exp_q.size();
      op_vec = 4'b0010;
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin n_bad++; $display("FAIL lid_at%0d[%0d]: got %b want %b", c, i, outs, e); end
         if (i == c - 1) lid = 1'b1;
         if (i == c + 2) lid = 1'b0;
`ifdef WM_LID_PAUSE_EN
         if (i == n - 2) op_vec = 4'd0;
`else
         if (i == c + 2) begin reset = 1'b1; op_vec = 4'd0; end
`endif
      end
      reset = 1'b0;
      op_vec = 4'd0;
      lid = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      int c, n;
      logic [10:0] e;
      c = $urandom_range(1, 7);
      exp_q.delete();
      model_phase(0, 1'b1);
      while (exp_q.size() > c) void'(exp_q.pop_back());
      exp_q.push_back(11'd0);
      model_phase(0, 1'b1);
      model_done(0, 1);
      n = exp_q.size();
      water_Intake = 1'b1;
      op_vec = 4'b0001;
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (outs !== e) begin n_bad++; $display("FAIL reset_mid_fill_at%0d[%0d]: got %b want %b", c, i, outs, e); end
         if (i == c - 1) reset = 1'b1;
         if (i == c) reset = 1'b0;
         if (i == n - 2) op_vec = 4'd0;
      end
      water_Intake = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wash_fill();
      test_random_ops();
      test_cancel();
      test_back_to_back();
      test_multi_op_fault();
      test_lid();
      test_reset_mid_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
